// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit: widens an IN_W immediate to OUT_W in one of
// four modes, with a registered valid/ready output stage backed by a one-entry skid.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             trunc_o
);

  // Returns {trunc, extended_value}. For mode 3 the SHAMT bits that fall off the top,
  // together with the new MSB, are exactly sext[OUT_W-1 : OUT_W-1-SHAMT].
  function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] d, input logic [1:0] m);
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] res;
    logic [SHAMT:0]   top;
    logic             s;
    logic             trunc;
    s     = d[IN_W-1];
    zext  = OUT_W'(d);
    sext  = OUT_W'($signed(d));
    top   = (SHAMT+1)'(sext >> (OUT_W-1-SHAMT));
    trunc = 1'b0;
    case (m)
      2'd0: res = zext;
      2'd1: res = sext;
      2'd2: res = zext << (OUT_W-IN_W);
      2'd3: begin
        res   = sext << SHAMT;
        trunc = (top != {(SHAMT+1){s}});
      end
      default: res = zext;
    endcase
    return {trunc, res};
  endfunction

  logic [OUT_W:0]   ext_s;
  logic             accept_s;
  logic             xfer_s;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic             out_trunc_r;
  logic             skid_valid_r;
  logic [OUT_W-1:0] skid_data_r;
  logic             skid_trunc_r;

  // Input-side extension and handshake qualifiers.
  always_comb begin
    ext_s    = extend(data_i, mode_i);
    accept_s = valid_i & ~skid_valid_r;
    xfer_s   = out_valid_r & ready_i;
  end

  // Output register and skid register; a full skid always drains before new accepts.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_trunc_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_trunc_r <= 1'b0;
    end else if (skid_valid_r) begin
      if (xfer_s) begin
        out_data_r   <= skid_data_r;
        out_trunc_r  <= skid_trunc_r;
        skid_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      if (!out_valid_r || xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= ext_s[OUT_W-1:0];
        out_trunc_r <= ext_s[OUT_W];
      end else begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= ext_s[OUT_W-1:0];
        skid_trunc_r <= ext_s[OUT_W];
      end
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign ready_o = ~skid_valid_r;
  assign valid_o = out_valid_r;
  assign data_o  = out_data_r;
  assign trunc_o = out_trunc_r;

endmodule
